alu_share_arbiter: RTL and testbench

- Shares the single combinational 32-bit ALU between two requesters: port 0 is the main datapath and port 1 is the exception/CP0 unit.
- Each port uses a valid/ready request channel and a valid/ready response channel.
- Operands are registered, and the block drives the ALU from those registers.
- The ALU result, zero and overflow are captured and returned to the owning requester.

---
 rtl/alu_arb_pkg.sv | 5 +
 rtl/rr_arb2.sv | 9 +
 rtl/alu_share_arbiter.sv | 89 ++++++++
 tb/tb_alu_share_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: FSM encoding and ALU opcodes shared by the ALU share arbiter and its benches
package alu_arb_pkg;
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1, S_RESP = 2'd2} state_t;
   localparam logic [2:0] AND = 3'b000, OR = 3'b001, ADD = 3'b010, SUB = 3'b110, SLT = 3'b111;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way arbiter, round-robin against last_grant or fixed priority to port 0
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last_grant,
   input  logic       fixed_prio,
   output logic [1:0] gnt
);
   always_comb gnt = (req == 2'b11) ? ((fixed_prio || last_grant) ? 2'b01 : 2'b10) : req;
endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: time-shares one combinational ALU between the datapath and the CP0 unit
module alu_share_arbiter import alu_arb_pkg::*; #(
   parameter int WIDTH      = 32,
   parameter int OP_W       = 3,
   parameter int FIXED_PRIO = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [OP_W-1:0]  req0_op,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [OP_W-1:0]  req1_op,
   output logic             rsp0_valid,
   input  logic             rsp0_ready,
   output logic             rsp1_valid,
   input  logic             rsp1_ready,
   output logic [WIDTH-1:0] rsp_res,
   output logic             rsp_zero,
   output logic             rsp_overflow,
   output logic [WIDTH-1:0] alu_A,
   output logic [WIDTH-1:0] alu_B,
   output logic [OP_W-1:0]  alu_op,
   input  logic [WIDTH-1:0] alu_res,
   input  logic             alu_zero,
   input  logic             alu_overflow,
   output logic             busy
);
   state_t     state, next_state;
   logic       owner, last_grant, accept, done;
   logic [1:0] gnt;

   rr_arb2 u_arb (
      .req        ({req1_valid, req0_valid}),
      .last_grant (last_grant),
      .fixed_prio (FIXED_PRIO != 0),
      .gnt        (gnt)
   );

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= S_IDLE;
      else        state <= next_state;

   // an illegal encoding falls back to IDLE
   always_comb
      next_state = (state == S_IDLE) ? (accept ? S_EXEC : S_IDLE) :
                   (state == S_EXEC) ? S_RESP :
                   (state == S_RESP && !done) ? S_RESP : S_IDLE;

   always_comb begin
      req0_ready = rst_n && state == S_IDLE && gnt[0];
      req1_ready = rst_n && state == S_IDLE && gnt[1];
      rsp0_valid = state == S_RESP && !owner;
      rsp1_valid = state == S_RESP && owner;
      busy       = state != S_IDLE;
      accept     = req0_ready || req1_ready;
      done       = state == S_RESP && (owner ? rsp1_ready : rsp0_ready);
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         alu_A        <= '0;
         alu_B        <= '0;
         alu_op       <= '0;
         rsp_res      <= '0;
         rsp_zero     <= 1'b0;
         rsp_overflow <= 1'b0;
         owner        <= 1'b0;
         last_grant   <= 1'b1;
      end else begin
         if (accept) begin
            alu_A  <= gnt[1] ? req1_a : req0_a;
            alu_B  <= gnt[1] ? req1_b : req0_b;
            alu_op <= gnt[1] ? req1_op : req0_op;
            owner  <= gnt[1];
         end
         if (state == S_EXEC) begin
            rsp_res      <= alu_res;
            rsp_zero     <= alu_zero;
            rsp_overflow <= alu_overflow;
         end
         if (done) last_grant <= owner;
      end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed bench with an external ALU model; round-robin and fixed-priority instances
module tb_alu_share_arbiter;
   import alu_arb_pkg::*;
   logic clk = 0, rst_n = 1;
   always #5 clk = ~clk;
   logic req0_valid = 0, req1_valid = 0, rsp0_ready = 0, rsp1_ready = 0;
   logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
   logic [2:0] req0_op = 0, req1_op = 0;
   logic req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_zero, rsp_overflow, busy, alu_zero, alu_overflow;
   logic [31:0] rsp_res, alu_A, alu_B, alu_res;
   logic [2:0] alu_op;
   logic fp_req0_ready, fp_req1_ready, fp_rsp0_valid, fp_rsp1_valid, fp_rsp_zero, fp_rsp_overflow, fp_busy, fp_alu_zero, fp_alu_overflow;
   logic [31:0] fp_rsp_res, fp_alu_A, fp_alu_B, fp_alu_res;
   logic [2:0] fp_alu_op;
   int checks = 0, failures = 0;

   function automatic logic [33:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
      logic [31:0] r;
      logic v;
      r = 0;
      v = 0;
      case (op)
         AND: r = a & b;
         OR:  r = a | b;
         ADD: begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
         SUB: begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
         SLT: r = {31'b0, $signed(a) < $signed(b)};
         default: r = 0;
      endcase
      return {v, r == 0, r};
   endfunction

   assign {alu_overflow, alu_zero, alu_res} = alu_f(alu_A, alu_B, alu_op);
   assign {fp_alu_overflow, fp_alu_zero, fp_alu_res} = alu_f(fp_alu_A, fp_alu_B, fp_alu_op);

   alu_share_arbiter #(.WIDTH(32), .OP_W(3), .FIXED_PRIO(0)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
      .rsp_res(rsp_res), .rsp_zero(rsp_zero), .rsp_overflow(rsp_overflow),
      .alu_A(alu_A), .alu_B(alu_B), .alu_op(alu_op),
      .alu_res(alu_res), .alu_zero(alu_zero), .alu_overflow(alu_overflow), .busy(busy)
   );

   alu_share_arbiter #(.WIDTH(32), .OP_W(3), .FIXED_PRIO(1)) dut_fp (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(fp_req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
      .req1_valid(req1_valid), .req1_ready(fp_req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
      .rsp0_valid(fp_rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(fp_rsp1_valid), .rsp1_ready(rsp1_ready),
      .rsp_res(fp_rsp_res), .rsp_zero(fp_rsp_zero), .rsp_overflow(fp_rsp_overflow),
      .alu_A(fp_alu_A), .alu_B(fp_alu_B), .alu_op(fp_alu_op),
      .alu_res(fp_alu_res), .alu_zero(fp_alu_zero), .alu_overflow(fp_alu_overflow), .busy(fp_busy)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
      rst_n = 0;
      repeat (2) tick();
      rst_n = 1;
      tick();
   endtask

   task automatic test_reset;
      #1 rst_n = 0;
      #2;
      checks++;
      if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy} !== 5'b0) begin
         failures++; $display("FAIL reset_hs got=%b exp=00000", {req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy});
      end
      checks++;
      if ({rsp_res, rsp_zero, rsp_overflow, alu_A, alu_B, alu_op} !== '0) begin
         failures++; $display("FAIL reset_regs got res=%h z=%b v=%b A=%h B=%h op=%h exp=all zero", rsp_res, rsp_zero, rsp_overflow, alu_A, alu_B, alu_op);
      end
      tick();
      rst_n = 1;
      tick();
   endtask

   task automatic test_single_p0;
      req0_a = 32'hA5A5A5A5; req0_b = 32'h5A5A5A5A; req0_op = ADD; req0_valid = 1; rsp0_ready = 1;
      #1;
      checks++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         failures++; $display("FAIL p0_accept got=%b exp=10", {req0_ready, req1_ready});
      end
      tick();
      req0_valid = 0;
      checks++;
      if ({busy, rsp0_valid, rsp1_valid, req0_ready} !== 4'b1000) begin
         failures++; $display("FAIL p0_exec got=%b exp=1000", {busy, rsp0_valid, rsp1_valid, req0_ready});
      end
      checks++;
      if ({alu_A, alu_B, alu_op} !== {32'hA5A5A5A5, 32'h5A5A5A5A, ADD}) begin
         failures++; $display("FAIL p0_alu_drive got=%h/%h/%h exp=a5a5a5a5/5a5a5a5a/2", alu_A, alu_B, alu_op);
      end
      tick();
      checks++;
      if ({rsp0_valid, rsp1_valid} !== 2'b10) begin
         failures++; $display("FAIL p0_rsp_valid got=%b exp=10", {rsp0_valid, rsp1_valid});
      end
      checks++;
      if ({rsp_res, rsp_zero, rsp_overflow} !== {32'hFFFFFFFF, 2'b00}) begin
         failures++; $display("FAIL p0_rsp_data got=%h z=%b v=%b exp=ffffffff z=0 v=0", rsp_res, rsp_zero, rsp_overflow);
      end
      tick();
      checks++;
      if ({rsp0_valid, busy} !== 2'b00) begin
         failures++; $display("FAIL p0_complete got=%b exp=00", {rsp0_valid, busy});
      end
   endtask

   task automatic test_port1;
      req1_a = 32'h01234567; req1_b = 32'h01234567; req1_op = SUB; req1_valid = 1; rsp1_ready = 1;
      #1;
      checks++;
      if ({req0_ready, req1_ready} !== 2'b01) begin
         failures++; $display("FAIL p1_accept got=%b exp=01", {req0_ready, req1_ready});
      end
      tick();
      req1_valid = 0;
      checks++;
      if ({rsp0_valid, rsp1_valid} !== 2'b00) begin
         failures++; $display("FAIL p1_exec_valid got=%b exp=00", {rsp0_valid, rsp1_valid});
      end
      tick();
      checks++;
      if ({rsp0_valid, rsp1_valid} !== 2'b01) begin
         failures++; $display("FAIL p1_rsp_valid got=%b exp=01", {rsp0_valid, rsp1_valid});
      end
      checks++;
      if ({rsp_res, rsp_zero, rsp_overflow} !== {32'h0, 2'b10}) begin
         failures++; $display("FAIL p1_rsp_data got=%h z=%b v=%b exp=00000000 z=1 v=0", rsp_res, rsp_zero, rsp_overflow);
      end
      tick();
      checks++;
      if ({rsp0_valid, rsp1_valid, busy} !== 3'b000) begin
         failures++; $display("FAIL p1_complete got=%b exp=000", {rsp0_valid, rsp1_valid, busy});
      end
   endtask

   task automatic test_overflow;
      req0_a = 32'h7FFFFFFF; req0_b = 32'h00000001; req0_op = ADD; req0_valid = 1; rsp0_ready = 1;
      tick();
      req0_valid = 0;
      tick();
      checks++;
      if ({rsp0_valid, rsp_res, rsp_zero, rsp_overflow} !== {1'b1, 32'h80000000, 2'b01}) begin
         failures++; $display("FAIL ovf_rsp got v=%b res=%h z=%b ovf=%b exp v=1 res=80000000 z=0 ovf=1", rsp0_valid, rsp_res, rsp_zero, rsp_overflow);
      end
      tick();
   endtask

   task automatic test_round_robin;
      logic [1:0] exp_g;
      do_reset();
      req0_a = 10; req0_b = 3; req0_op = ADD;
      req1_a = 10; req1_b = 3; req1_op = SUB;
      req0_valid = 1; req1_valid = 1; rsp0_ready = 1; rsp1_ready = 1;
      for (int i = 0; i < 4; i++) begin
         exp_g = (i % 2 == 1) ? 2'b10 : 2'b01;
         #1;
         checks++;
         if ({req1_ready, req0_ready} !== exp_g) begin
            failures++; $display("FAIL rr_grant%0d got=%b exp=%b", i, {req1_ready, req0_ready}, exp_g);
         end
         tick();
         tick();
         checks++;
         if ({rsp1_valid, rsp0_valid} !== exp_g) begin
            failures++; $display("FAIL rr_route%0d got=%b exp=%b", i, {rsp1_valid, rsp0_valid}, exp_g);
         end
         checks++;
         if (rsp_res !== (exp_g[1] ? 32'd7 : 32'd13)) begin
            failures++; $display("FAIL rr_res%0d got=%0d exp=%0d", i, rsp_res, exp_g[1] ? 7 : 13);
         end
         tick();
      end
      req0_valid = 0; req1_valid = 0;
   endtask

   task automatic test_backpressure;
      do_reset();
      req0_a = 3; req0_b = 5; req0_op = OR; req0_valid = 1;
      #1;
      checks++;
      if (req0_ready !== 1'b1) begin
         failures++; $display("FAIL bp_accept got=%b exp=1", req0_ready);
      end
      tick();
      req0_valid = 0;
      req1_a = 1; req1_b = 1; req1_op = ADD; req1_valid = 1;
      tick();
      for (int i = 0; i < 5; i++) begin
         checks++;
         if ({rsp0_valid, busy, req1_ready, rsp_res} !== {3'b110, 32'd7}) begin
            failures++; $display("FAIL bp_hold%0d got v=%b busy=%b r1=%b res=%h exp v=1 busy=1 r1=0 res=7", i, rsp0_valid, busy, req1_ready, rsp_res);
         end
         tick();
      end
      rsp0_ready = 1;
      tick();
      checks++;
      if ({rsp0_valid, req1_ready} !== 2'b01) begin
         failures++; $display("FAIL bp_release got=%b exp=01", {rsp0_valid, req1_ready});
      end
      tick();
      req1_valid = 0;
      tick();
      checks++;
      if ({rsp1_valid, rsp_res} !== {1'b1, 32'd2}) begin
         failures++; $display("FAIL bp_next got v=%b res=%h exp v=1 res=2", rsp1_valid, rsp_res);
      end
      rsp1_ready = 1;
      tick();
   endtask

   task automatic test_reset_mid_and_fixed;
      req0_a = 1; req0_b = 2; req0_op = ADD; req0_valid = 1; rsp0_ready = 1; rsp1_ready = 1;
      tick();
      req0_valid = 0;
      #2 rst_n = 0;
      #1;
      checks++;
      if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy, fp_busy, fp_rsp_zero, fp_rsp_overflow} !== 8'b0) begin
         failures++; $display("FAIL mid_reset_hs got=%b exp=00000000", {req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy, fp_busy, fp_rsp_zero, fp_rsp_overflow});
      end
      checks++;
      if ({alu_A, alu_B, alu_op, rsp_res} !== '0) begin
         failures++; $display("FAIL mid_reset_regs got A=%h B=%h op=%h res=%h exp=0", alu_A, alu_B, alu_op, rsp_res);
      end
      tick();
      rst_n = 1;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if ({rsp0_valid, rsp1_valid, busy} !== 3'b000) begin
            failures++; $display("FAIL mid_reset_quiet%0d got=%b exp=000", i, {rsp0_valid, rsp1_valid, busy});
         end
      end
      req0_a = 4; req0_b = 4; req0_op = AND;
      req1_a = 4; req1_b = 1; req1_op = SUB;
      req0_valid = 1; req1_valid = 1;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if ({fp_req1_ready, fp_req0_ready} !== 2'b01) begin
            failures++; $display("FAIL fp_grant%0d got=%b exp=01", i, {fp_req1_ready, fp_req0_ready});
         end
         tick();
         tick();
         checks++;
         if ({fp_rsp1_valid, fp_rsp0_valid, fp_rsp_res} !== {2'b01, 32'd4}) begin
            failures++; $display("FAIL fp_rsp%0d got v=%b res=%h exp v=01 res=4", i, {fp_rsp1_valid, fp_rsp0_valid}, fp_rsp_res);
         end
         tick();
      end
      req0_valid = 0; req1_valid = 0;
   endtask

   initial begin
      test_reset();
      test_single_p0();
      test_port1();
      test_overflow();
      test_round_robin();
      test_backpressure();
      test_reset_mid_and_fixed();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
